ps2_mouse_pkt_decoder: RTL and testbench

//  Consumes the byte stream from the PS/2 byte receiver, frames it into standard 3-byte mouse packets,
//  and accumulates the signed X/Y deltas into clamped absolute coordinates.

---
 rtl/ps2_pkg.sv | 43 ++++
 rtl/ps2_pos_accum.sv | 51 +++++
 rtl/ps2_mouse_pkt_decoder.sv | 169 ++++++++++++++++
 tb/tb_ps2_mouse_pkt_decoder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Purpose  : Shared types and constants for the PS/2 mouse packet decoder.
//             Holds the framing FSM state type, the byte0 bit positions of a
//             standard 3-byte mouse packet and the delta decode helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2,
    UPDATE  = 2'd3
  } ps2_state_t;

  // byte0 bit positions
  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;
  localparam int SYNC  = 3;
  localparam int XS    = 4;
  localparam int YS    = 5;
  localparam int XO    = 6;
  localparam int YO    = 7;

  // Build the 9-bit two's-complement delta from the sign bit in byte0 and the
  // low byte. An axis whose overflow bit is set carries no usable magnitude,
  // so it contributes no movement.
  function automatic logic signed [8:0] decode_delta(
    input logic       sign,
    input logic [7:0] low,
    input logic       ovf
  );
    logic signed [8:0] d;
    d = ovf ? 9'sd0 : $signed({sign, low});
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_pos_accum.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pos_accum
//  Purpose  : One-axis position accumulator. Adds a signed 9-bit delta to the
//             current position and saturates the result to 0..MAX.
//  Ports    : clk   - system clock
//             rst   - synchronous active-high reset, clears the position
//             en    - apply delta this cycle
//             delta - signed 9-bit movement
//             pos   - clamped 8-bit position register
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_pos_accum #(
  parameter int MAX = 99
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic signed [8:0] delta,
  output logic [7:0]        pos
);

  localparam logic signed [10:0] C_MAX11 = 11'(MAX);
  localparam logic [7:0]         C_MAX8  = 8'(MAX);

  logic signed [10:0] w_sum;
  logic [7:0]         w_pos_next;

  // 11 bits holds 0..255 plus -256..255 without wrap, so the clamp below
  // always sees the true arithmetic result.
  assign w_sum = $signed({3'b000, pos}) + $signed({{2{delta[8]}}, delta});

  always_comb begin
    w_pos_next = w_sum[7:0];
    if (w_sum < 11'sd0) begin
      w_pos_next = 8'd0;
    end else if (w_sum > C_MAX11) begin
      w_pos_next = C_MAX8;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos <= 8'd0;
    end else if (en) begin
      pos <= w_pos_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_mouse_pkt_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_mouse_pkt_decoder
//  Purpose  : Frames the PS/2 receive byte stream into 3-byte mouse packets,
//             decodes buttons and signed X/Y deltas, and accumulates clamped
//             absolute coordinates for the display path.
//  Ports    : clk, rst                 - clock, synchronous active-high reset
//             rx_data, rx_vld          - received byte and its 1-cycle strobe
//             init_done                - streaming enabled
//             pkt_vld                  - 1-cycle pulse, new packet applied
//             left/right/middle_button - buttons of the last good packet
//             x_coord, y_coord         - accumulated, clamped position
//             pkt_cnt_o                - good-packet counter, mod 8
//             seq_error, ovf_error     - sticky error flags
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_mouse_pkt_decoder
  import ps2_pkg::*;
#(
  parameter int X_MAX       = 99,
  parameter int Y_MAX       = 99,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_vld,
  input  logic       init_done,
  output logic       pkt_vld,
  output logic       left_button,
  output logic       right_button,
  output logic       middle_button,
  output logic [7:0] x_coord,
  output logic [7:0] y_coord,
  output logic [2:0] pkt_cnt_o,
  output logic       seq_error,
  output logic       ovf_error
);

  localparam int            C_TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [C_TW-1:0] C_TMO_LAST = C_TW'(TIMEOUT_CYC - 1);

  ps2_state_t        r_state, w_state_nxt;
  logic [C_TW-1:0]   r_tmo, w_tmo_nxt;
  logic [7:0]        r_byte0, r_byte1, r_byte2;
  logic              w_lat0, w_lat1, w_lat2;
  logic              w_seq_set;
  logic              w_update;
  logic signed [8:0] w_dx, w_dy;

  // --------------------------------------------------------------------------
  // Next-state logic. A byte arriving in UPDATE is treated as a fresh byte0 so
  // back-to-back packets lose nothing; the update itself still uses the
  // previously latched bytes because they are only overwritten at the edge.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_tmo_nxt   = '0;
    w_lat0      = 1'b0;
    w_lat1      = 1'b0;
    w_lat2      = 1'b0;
    w_seq_set   = 1'b0;
    w_update    = 1'b0;

    if (!init_done) begin
      // Streaming disabled: abandon any partial packet silently.
      w_state_nxt = WAIT_B0;
    end else begin
      case (r_state)
        WAIT_B0, UPDATE: begin
          w_update    = (r_state == UPDATE);
          w_state_nxt = WAIT_B0;
          if (rx_vld) begin
            if (rx_data[SYNC]) begin
              w_lat0      = 1'b1;
              w_state_nxt = WAIT_B1;
            end else begin
              w_seq_set = 1'b1;
            end
          end
        end

        WAIT_B1, WAIT_B2: begin
          // A byte on the expiry cycle takes priority over the timeout.
          if (rx_vld) begin
            if (r_state == WAIT_B1) begin
              w_lat1      = 1'b1;
              w_state_nxt = WAIT_B2;
            end else begin
              w_lat2      = 1'b1;
              w_state_nxt = UPDATE;
            end
          end else if (r_tmo == C_TMO_LAST) begin
            w_seq_set   = 1'b1;
            w_state_nxt = WAIT_B0;
          end else begin
            w_tmo_nxt = r_tmo + 1'b1;
          end
        end

        default: begin
          w_state_nxt = WAIT_B0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WAIT_B0;
      r_tmo   <= '0;
      r_byte0 <= 8'd0;
      r_byte1 <= 8'd0;
      r_byte2 <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_tmo   <= w_tmo_nxt;
      if (w_lat0) r_byte0 <= rx_data;
      if (w_lat1) r_byte1 <= rx_data;
      if (w_lat2) r_byte2 <= rx_data;
    end
  end

  // --------------------------------------------------------------------------
  // Packet decode and output registers.
  // --------------------------------------------------------------------------
  assign w_dx = decode_delta(r_byte0[XS], r_byte1, r_byte0[XO]);
  assign w_dy = decode_delta(r_byte0[YS], r_byte2, r_byte0[YO]);

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_vld       <= 1'b0;
      left_button   <= 1'b0;
      right_button  <= 1'b0;
      middle_button <= 1'b0;
      pkt_cnt_o     <= 3'd0;
      seq_error     <= 1'b0;
      ovf_error     <= 1'b0;
    end else begin
      pkt_vld <= w_update;
      if (w_update) begin
        left_button   <= r_byte0[BTN_L];
        right_button  <= r_byte0[BTN_R];
        middle_button <= r_byte0[BTN_M];
        pkt_cnt_o     <= pkt_cnt_o + 3'd1;
        if (r_byte0[XO] || r_byte0[YO]) ovf_error <= 1'b1;
      end
      if (w_seq_set) seq_error <= 1'b1;
    end
  end

  ps2_pos_accum #(.MAX(X_MAX)) u_x_accum (
    .clk   (clk),
    .rst   (rst),
    .en    (w_update),
    .delta (w_dx),
    .pos   (x_coord)
  );

  ps2_pos_accum #(.MAX(Y_MAX)) u_y_accum (
    .clk   (clk),
    .rst   (rst),
    .en    (w_update),
    .delta (w_dy),
    .pos   (y_coord)
  );

endmodule
`default_nettype wire

// File: tb/tb_ps2_mouse_pkt_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_mouse_pkt_decoder
//  Purpose  : Self-checking bench for ps2_mouse_pkt_decoder. Table of packets
//             with hand-computed results, plus directed multi-cycle cases
//             (back-to-back, init drop, framing error, timeout, overflow,
//             reset mid-packet).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_mouse_pkt_decoder;

  localparam int C_TMO = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       init_done;
  logic       pkt_vld;
  logic       left_button, right_button, middle_button;
  logic [7:0] x_coord, y_coord;
  logic [2:0] pkt_cnt_o;
  logic       seq_error, ovf_error;

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  ps2_mouse_pkt_decoder #(
    .X_MAX       (99),
    .Y_MAX       (99),
    .TIMEOUT_CYC (C_TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_vld        (rx_vld),
    .init_done     (init_done),
    .pkt_vld       (pkt_vld),
    .left_button   (left_button),
    .right_button  (right_button),
    .middle_button (middle_button),
    .x_coord       (x_coord),
    .y_coord       (y_coord),
    .pkt_cnt_o     (pkt_cnt_o),
    .seq_error     (seq_error),
    .ovf_error     (ovf_error)
  );

  always @(negedge clk) if (pkt_vld) pulses++;

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         x, y;
    logic [2:0] btn;   // {middle, right, left}
    int         cnt;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_vld  = 1'b1;
    @(negedge clk);
    rx_vld  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " x"}, x_coord, 0);
    chk({tag, " y"}, y_coord, 0);
    chk({tag, " btn"}, {middle_button, right_button, left_button}, 0);
    chk({tag, " cnt"}, pkt_cnt_o, 0);
    chk({tag, " seq"}, seq_error, 0);
    chk({tag, " ovf"}, ovf_error, 0);
    chk({tag, " pkt_vld"}, pkt_vld, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    chk_zero("reset");
    rst = 1'b0;
  endtask

  initial begin
    int p0;
    vecs[0]  = '{8'h08, 8'h05, 8'h03,  5,  3, 3'b000, 1};
    vecs[1]  = '{8'h19, 8'hF6, 8'h00,  0,  3, 3'b001, 2};
    vecs[2]  = '{8'h0E, 8'h02, 8'h01,  2,  4, 3'b110, 3};
    vecs[3]  = '{8'h28, 8'h00, 8'hFE,  2,  2, 3'b000, 4};
    vecs[4]  = '{8'h08, 8'h10, 8'h10, 18, 18, 3'b000, 5};
    vecs[5]  = '{8'h08, 8'h10, 8'h10, 34, 34, 3'b000, 6};
    vecs[6]  = '{8'h08, 8'h10, 8'h10, 50, 50, 3'b000, 7};
    vecs[7]  = '{8'h08, 8'h10, 8'h10, 66, 66, 3'b000, 0};
    vecs[8]  = '{8'h08, 8'h10, 8'h10, 82, 82, 3'b000, 1};
    vecs[9]  = '{8'h08, 8'h10, 8'h10, 98, 98, 3'b000, 2};
    vecs[10] = '{8'h08, 8'h10, 8'h10, 99, 99, 3'b000, 3};
    vecs[11] = '{8'h08, 8'h10, 8'h10, 99, 99, 3'b000, 4};
    vecs[12] = '{8'h18, 8'h9C, 8'h00,  0, 99, 3'b000, 5};
    vecs[13] = '{8'h08, 8'hFF, 8'h00, 99, 99, 3'b000, 6};

    rst = 1'b1; rx_data = 8'h00; rx_vld = 1'b0; init_done = 1'b1;
    idle(3);
    chk_zero("init");
    rst = 1'b0;
    idle(2);

    // ---- table-driven packets; outputs must land one edge after UPDATE ----
    for (int i = 0; i < 14; i++) begin
      send_byte(vecs[i].b0);
      send_byte(vecs[i].b1);
      send_byte(vecs[i].b2);
      chk($sformatf("v%0d early pkt_vld", i), pkt_vld, 0);
      @(negedge clk);
      chk($sformatf("v%0d pkt_vld", i), pkt_vld, 1);
      chk($sformatf("v%0d x", i), x_coord, vecs[i].x);
      chk($sformatf("v%0d y", i), y_coord, vecs[i].y);
      chk($sformatf("v%0d btn", i), {middle_button, right_button, left_button}, vecs[i].btn);
      chk($sformatf("v%0d cnt", i), pkt_cnt_o, vecs[i].cnt);
      @(negedge clk);
      chk($sformatf("v%0d pkt_vld drop", i), pkt_vld, 0);
    end
    chk("table seq", seq_error, 0);
    chk("table ovf", ovf_error, 0);

    // ---- reset mid-packet discards the partial packet ----
    send_byte(8'h08);
    send_byte(8'h05);
    do_reset();
    send_byte(8'h08); send_byte(8'h02); send_byte(8'h03);
    idle(3);
    chk("post-rst x", x_coord, 2);
    chk("post-rst y", y_coord, 3);
    chk("post-rst cnt", pkt_cnt_o, 1);

    // ---- back-to-back packets: second byte0 arrives during UPDATE ----
    p0 = pulses;
    @(negedge clk);
    foreach (vecs[0].b0[k]) begin end
    begin
      logic [7:0] stream [6];
      stream = '{8'h08, 8'h01, 8'h01, 8'h08, 8'h01, 8'h01};
      for (int k = 0; k < 6; k++) begin
        rx_data = stream[k];
        rx_vld  = 1'b1;
        @(negedge clk);
      end
      rx_vld = 1'b0;
    end
    idle(4);
    chk("b2b pulses", pulses - p0, 2);
    chk("b2b x", x_coord, 4);
    chk("b2b y", y_coord, 5);
    chk("b2b cnt", pkt_cnt_o, 3);

    // ---- init_done drop mid-packet: discard, no seq_error ----
    p0 = pulses;
    send_byte(8'h08);
    send_byte(8'h01);
    init_done = 1'b0;
    send_byte(8'h08);          // ignored while disabled
    idle(2);
    init_done = 1'b1;
    send_byte(8'h08); send_byte(8'h01); send_byte(8'h01);
    idle(3);
    chk("init-drop pulses", pulses - p0, 1);
    chk("init-drop x", x_coord, 5);
    chk("init-drop y", y_coord, 6);
    chk("init-drop seq", seq_error, 0);

    // ---- framing error: byte without sync bit is dropped ----
    p0 = pulses;
    send_byte(8'h05);
    idle(1);
    chk("sync seq", seq_error, 1);
    send_byte(8'h08); send_byte(8'h01); send_byte(8'h01);
    idle(3);
    chk("sync pulses", pulses - p0, 1);
    chk("sync x", x_coord, 6);
    chk("sync y", y_coord, 7);
    chk("sync cnt", pkt_cnt_o, 5);

    // ---- inter-byte timeout ----
    do_reset();
    p0 = pulses;
    send_byte(8'h08);
    send_byte(8'h01);
    idle(C_TMO);
    chk("tmo seq", seq_error, 1);
    send_byte(8'h08); send_byte(8'h02); send_byte(8'h02);
    idle(3);
    chk("tmo pulses", pulses - p0, 1);
    chk("tmo x", x_coord, 2);
    chk("tmo y", y_coord, 2);
    chk("tmo cnt", pkt_cnt_o, 1);

    // ---- X overflow bit ----
    chk("pre-ovf", ovf_error, 0);
    send_byte(8'h48); send_byte(8'hFF); send_byte(8'h04);
    idle(3);
    chk("ovf x", x_coord, 2);
    chk("ovf y", y_coord, 6);
    chk("ovf flag", ovf_error, 1);
    chk("ovf cnt", pkt_cnt_o, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
